// File: rtl/uart2wb_reply_pkg.sv
// Shared types and constants for the UART-to-Wishbone reply path.
// Request codes, FSM states, ASCII constants and char helpers.
package uart2wb_reply_pkg;

  typedef enum logic [1:0] {
    REQ_ECHO = 2'd0,
    REQ_ACK  = 2'd1,
    REQ_NAK  = 2'd2,
    REQ_HEX  = 2'd3
  } req_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_START,
    S_WAIT_DONE
  } state_e;

  typedef struct packed {
    req_type_e  typ;
    logic [7:0] dat;
  } req_t;

  localparam logic [7:0] ASCII_K   = 8'h6B;
  localparam logic [7:0] ASCII_N   = 8'h6E;
  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] ASCII_P   = 8'h70;
  localparam logic [7:0] ASCII_R   = 8'h72;
  localparam logic [7:0] ASCII_W   = 8'h77;

  // Uppercase only, matching the RX decoder.
  function automatic logic [7:0] hex_char(
    input logic [3:0] n
  );
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] reply_char(
    input req_t r,
    input logic lo
  );
    logic [7:0] c;
    c = r.dat;
    unique case (1'b1)
      r.typ == REQ_ACK: c = ASCII_K;
      r.typ == REQ_NAK: c = ASCII_N;
      r.typ == REQ_HEX:
        c = lo ? hex_char(r.dat[3:0])
               : hex_char(r.dat[7:4]);
      default: c = r.dat;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart2wb_reply_sync_fifo.sv
// Synchronous FIFO with full/empty flags and show-ahead head.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data, full, empty.
module uart2wb_reply_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ONE;
      if (do_rd) rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_wr)
      mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart2wb_reply.sv
// Reply transmitter: queues reply requests, emits ASCII to UART TX.
// Ports: i_wb_clk/i_wb_rst, i_req_*/o_req_ready, o_tx_dat/o_send, i_tx_busy, o_idle.
module uart2wb_reply
  import uart2wb_reply_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_wb_clk,
  input  logic       i_wb_rst,
  input  logic       i_req_valid,
  input  logic [1:0] i_req_type,
  input  logic [7:0] i_req_dat,
  output logic       o_req_ready,
  output logic [7:0] o_tx_dat,
  output logic       o_send,
  input  logic       i_tx_busy,
  output logic       o_idle
);

  req_t   wr_req;
  req_t   rd_req;
  req_t   hold;
  state_e state;
  logic   lo;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  assign wr_req.typ = req_type_e'(i_req_type);
  assign wr_req.dat = i_req_dat;

  assign push = i_req_valid & ~full;
  assign pop  = (state == S_IDLE) & ~empty;

  assign o_req_ready = ~full;
  assign o_idle      = (state == S_IDLE) & empty;

  uart2wb_reply_sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_wb_clk),
    .rst     (i_wb_rst),
    .wr_en   (push),
    .wr_data (wr_req),
    .rd_en   (pop),
    .rd_data (rd_req),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state    <= S_IDLE;
      hold     <= '0;
      lo       <= 1'b0;
      o_send   <= 1'b0;
      o_tx_dat <= 8'h00;
    end else begin
      o_send <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            hold     <= rd_req;
            lo       <= 1'b0;
            o_tx_dat <= reply_char(rd_req, 1'b0);
            o_send   <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: state <= S_WAIT_START;
        S_WAIT_START: begin
          if (i_tx_busy) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            // HEX needs a second character for the low nibble.
            if (hold.typ == REQ_HEX && !lo) begin
              lo       <= 1'b1;
              o_tx_dat <= reply_char(hold, 1'b1);
              o_send   <= 1'b1;
              state    <= S_SEND;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart2wb_reply.sv
// Self-checking bench for uart2wb_reply with a UART TX model.
// Expected characters are queued at push and checked at each strobe.
module tb_uart2wb_reply;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_type = 2'd0;
  logic [7:0] req_dat = 8'h00;
  logic       o_req_ready;
  logic [7:0] o_tx_dat;
  logic       o_send;
  logic       tx_busy;
  logic       o_idle;

  logic       m_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       busy_q = 1'b0;
  logic       prev_send = 1'b0;
  int         m_cnt = 0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];
  int         sc_q [$];

  assign tx_busy = m_busy | hold_busy;

  uart2wb_reply #(.FIFO_DEPTH(4)) dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (rst),
    .i_req_valid (req_valid),
    .i_req_type  (req_type),
    .i_req_dat   (req_dat),
    .o_req_ready (o_req_ready),
    .o_tx_dat    (o_tx_dat),
    .o_send      (o_send),
    .i_tx_busy   (tx_busy),
    .o_idle      (o_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= tx_busy;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    if (n > 4'd9) return 8'h37 + {4'h0, n};
    return 8'h30 + {4'h0, n};
  endfunction

  // UART TX model: busy for 3 cycles after each strobe.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) m_busy = 1'b0;
      end
      if (o_send === 1'b1) begin
        check("send_pulse", {31'd0, prev_send}, 0);
        check("busy_at_send", {31'd0, busy_q}, 0);
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_dat", {24'd0, o_tx_dat}, {24'd0, e});
        end
        sc_q.push_back(cyc);
        m_busy = 1'b1;
        m_cnt  = 3;
      end
      prev_send = o_send;
    end
  end

  task automatic push(input logic [1:0] t, input logic [7:0] d);
    req_valid = 1'b1;
    req_type  = t;
    req_dat   = d;
    if (o_req_ready) begin
      case (t)
        2'd0: exp_q.push_back(d);
        2'd1: exp_q.push_back(8'h6B);
        2'd2: exp_q.push_back(8'h6E);
        default: begin
          exp_q.push_back(hx(d[7:4]));
          exp_q.push_back(hx(d[3:0]));
        end
      endcase
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (o_idle && exp_q.size() == 0 && !m_busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check(tag, {31'd0, done}, 1);
    check({tag, "_idle"}, {31'd0, o_idle}, 1);
  endtask

  task automatic wait_send(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (o_send === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, got}, 1);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_send", {31'd0, o_send}, 0);
    check("rst_dat", {24'd0, o_tx_dat}, 0);
    check("rst_ready", {31'd0, o_req_ready}, 1);
    check("rst_idle", {31'd0, o_idle}, 1);

    // ACK then NAK with latency check
    sc_q.delete();
    c = cyc;
    push(2'd1, 8'h00);
    push(2'd2, 8'h00);
    drain("ack_nak_drain");
    check("ack_nak_count", sc_q.size(), 2);
    if (sc_q.size() > 0)
      check("ack_latency", sc_q[0] - c, 2);

    // HEX conversions
    push(2'd3, 8'h3C);
    push(2'd3, 8'hA5);
    push(2'd3, 8'h09);
    drain("hex_drain");

    // ECHO passes data through
    push(2'd0, 8'h70);
    push(2'd0, 8'h77);
    drain("echo_drain");

    // Stall UART, fill the queue
    push(2'd0, 8'h5A);
    wait_send("stall_send");
    hold_busy = 1'b1;
    @(posedge clk);
    #1;
    push(2'd1, 8'h00);
    push(2'd0, 8'h55);
    push(2'd3, 8'hB7);
    check("pre_full_ready", {31'd0, o_req_ready}, 1);
    push(2'd2, 8'h00);
    check("full_ready", {31'd0, o_req_ready}, 0);
    check("full_idle", {31'd0, o_idle}, 0);
    push(2'd0, 8'h21);
    check("refused_ready", {31'd0, o_req_ready}, 0);

    // Release; push while full and popping
    hold_busy = 1'b0;
    @(posedge clk);
    #1;
    check("pop_cycle_ready", {31'd0, o_req_ready}, 0);
    push(2'd1, 8'h00);
    check("after_pop_ready", {31'd0, o_req_ready}, 1);
    drain("full_drain");

    // Reset between the two HEX characters
    push(2'd3, 8'hFF);
    wait_send("hexff_first");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_pending", exp_q.size(), 1);
    exp_q.delete();
    check("mid_rst_send", {31'd0, o_send}, 0);
    check("mid_rst_dat", {24'd0, o_tx_dat}, 0);
    check("mid_rst_ready", {31'd0, o_req_ready}, 1);
    check("mid_rst_idle", {31'd0, o_idle}, 1);
    sc_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("no_second_strobe", sc_q.size(), 0);
    c = cyc;
    push(2'd1, 8'h00);
    drain("post_rst_drain");
    check("post_rst_count", sc_q.size(), 1);
    if (sc_q.size() > 0)
      check("post_rst_latency", sc_q[0] - c, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart2wb_reply.md
# uart2wb_reply

Reply transmitter for the UART-to-Wishbone bridge. It accepts reply requests from the bridge command decoder (echo, `k` acknowledge, `n` error, hex data byte), queues them, and serialises them as ASCII characters to the UART transmitter. It is the TX-side counterpart of the bridge's RX command decoder and sits between bridge control logic and the UART TX core.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, request queue entries; power of two, at least 2.

Ports:
- `i_wb_clk` in 1: system clock; the only clock.
- `i_wb_rst` in 1: synchronous, active-high reset.
- `i_req_valid` in 1: reply request present.
- `i_req_type` in 2: 0 ECHO, 1 ACK, 2 NAK, 3 HEX.
- `i_req_dat` in 8: byte to echo (ECHO) or value to print (HEX); ignored for ACK and NAK.
- `o_req_ready` out 1: queue not full; a request is accepted when `i_req_valid & o_req_ready`.
- `o_tx_dat` out 8: character to the UART TX.
- `o_send` out 1: one-cycle strobe, character on `o_tx_dat` valid.
- `i_tx_busy` in 1: UART TX shifting a character.
- `o_idle` out 1: queue empty and FSM in IDLE.

## Operation
- Request queue: synchronous FIFO of `FIFO_DEPTH` x {type[1:0], dat[7:0]}.
- Character mapping:
  - ECHO sends `dat` verbatim.
  - ACK sends 0x6B (`k`).
  - NAK sends 0x6E (`n`).
  - HEX sends two characters, high nibble first. Nibble 0-9 maps to 0x30+n; A-F map to 0x41+(n-10), uppercase only, to match the decoder.
- FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
  - IDLE: if the queue is non-empty, pop the head into holding registers, clear the nibble flag, go to SEND.
  - SEND: `o_send`=1 for exactly this cycle. `o_tx_dat` is the current character (HEX with flag 0 gives the high nibble; flag 1 gives the low nibble). Go to WAIT_START.
  - WAIT_START: stay until `i_tx_busy`=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `i_tx_busy`=0. Then, if HEX and flag=0: set flag, go to SEND. Otherwise go to IDLE.
- `o_tx_dat` is registered. It is loaded on entry to SEND and held stable until the next SEND.

## Timing
- Reset values: `o_send`=0, `o_tx_dat`=0x00, `o_req_ready`=1, `o_idle`=1. The queue is emptied, the FSM is in IDLE, and the nibble flag is 0.
- Latency, empty queue: request accepted at cycle N gives `o_send`=1 at cycle N+2.
- Back-to-back characters: the next SEND comes no earlier than 1 cycle after `i_tx_busy` falls.
- `o_req_ready` depends on the full flag only. When the queue is full, a push is refused even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full, non-empty queue: both take effect and the occupancy is unchanged.
- Push to an empty queue while in IDLE: the entry is visible (pop-able) from the next cycle. There is no bypass.
- Reset mid-operation:
  - Any character not yet strobed is dropped, along with all queued requests.
  - A character already handed to the UART completes there.
  - After reset, the FSM ignores `i_tx_busy` until the next SEND.
- `i_tx_busy` is assumed to rise after `o_send`. If it never rises, the FSM waits in WAIT_START indefinitely (no timeout).
- `o_idle` is combinational from the registered state and the empty flag.

## Structure
- Shared header `uart2wb_defs.vh`, used by both the bridge decoder and this block:
  - request type codes REQ_ECHO/ACK/NAK/HEX;
  - ASCII constants for `k` 0x6B, `n` 0x6E, `.` 0x2E, `p` 0x70, `r` 0x72, `w` 0x77;
  - a nibble-to-ASCII hex function.
- Sub-module `sync_fifo`, parameterised by width and depth, with full/empty flags. It is reusable for the RX side.

## Test plan
- Reset, then push ACK, NAK: exactly two `o_send` strobes, carrying 0x6B then 0x6E. The first strobe is 2 cycles after acceptance, and each strobe waits for a busy high-then-low cycle.
- Push HEX 0x3C: strobes carry 0x33 then 0x43. HEX 0xA5 gives 0x41 then 0x35. HEX 0x09 gives 0x30 then 0x39.
- Push ECHO 0x70 (`p`), then ECHO 0x77: 0x70 then 0x77 are sent unchanged.
- Hold `i_tx_busy` high; push 4 requests (DEPTH 4): `o_req_ready`=0 after the 4th. A 5th request is refused. After busy is released, all 4 are sent in order and `o_idle` returns to 1.
- Push HEX 0xFF; assert `i_wb_rst` for 1 cycle after the first strobe: no second strobe. Outputs return to their reset values, and a following ACK sends 0x6B with normal latency.
- Push ACK while the queue is full and a pop occurs in the same cycle: the push is refused, and occupancy drops by 1.
